// File: rtl/multi_mode_decimator_if.sv
// Bus between ADC capture and multi_mode_decimator: config, gated samples and decimated results.
interface multi_mode_decimator_if #(
   parameter int DW  = 12,
   parameter int NCH = 2,
   parameter int RW  = 12
);
   logic [RW-1:0]     deci_rate;
   logic [1:0]        mode;
   logic [3:0]        avg_log2;
   logic              restart;
   logic              din_valid;
   logic [NCH*DW-1:0] din;
   logic              dout_valid;
   logic [NCH*DW-1:0] dout;
   logic [NCH*DW-1:0] dout_min;

   modport master (
      output deci_rate, mode, avg_log2, restart, din_valid, din,
      input  dout_valid, dout, dout_min
   );

   modport slave (
      input  deci_rate, mode, avg_log2, restart, din_valid, din,
      output dout_valid, dout, dout_min
   );
endinterface

// File: rtl/multi_mode_decimator.sv
// N-channel block decimator (sample / peak min-max / average) on ad_clk.
// Average mode and its accumulators are built only when DECIM_AVG_EN is defined.
module multi_mode_decimator #(
   parameter int DW  = 12,
   parameter int NCH = 2,
   parameter int RW  = 12
) (
   input  logic ad_clk,
   input  logic rst_n,
   multi_mode_decimator_if.slave bus
);
   // wide enough for both max rate and a 1<<15 average block
   localparam int CW = (RW + 1 > 16) ? RW + 1 : 16;

   logic [RW-1:0] rate_l, rate_e;
   logic [1:0]    mode_l, mode_e;
   logic          first;
   logic [CW-1:0] cnt, last_idx;
   logic          accept, close, first_s, peak_e;
   logic [NCH*DW-1:0] nxt_dout, nxt_dmin;

   // the first edge after reset uses the ports directly, since nothing is latched yet
   assign rate_e  = first ? bus.deci_rate : rate_l;
   assign mode_e  = first ? bus.mode      : mode_l;
   assign peak_e  = (mode_e == 2'd1);
   assign accept  = bus.din_valid && !bus.restart;
   assign first_s = (cnt == '0);
   assign close   = accept && (cnt == last_idx);

`ifdef DECIM_AVG_EN
   logic [3:0] log2_l, log2_e;
   logic       avg_e;
   assign log2_e = first ? bus.avg_log2 : log2_l;
   assign avg_e  = (mode_e == 2'd2);

   always_comb begin
      if (avg_e)
         last_idx = (CW'(1) << log2_e) - CW'(1);
      else
         last_idx = (rate_e == '0) ? '0 : CW'(rate_e) - CW'(1);
   end

   always_ff @(posedge ad_clk or negedge rst_n) begin
      if (!rst_n)
         log2_l <= '0;
      else if (bus.restart || close || first)
         log2_l <= bus.avg_log2;
   end
`else
   logic unused_avg_log2;
   assign unused_avg_log2 = ^bus.avg_log2;

   always_comb begin
      last_idx = (rate_e == '0) ? '0 : CW'(rate_e) - CW'(1);
   end
`endif

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [DW-1:0] s, max_r, min_r, nxt_max, nxt_min, res;

      assign s       = bus.din[c*DW +: DW];
      assign nxt_max = first_s ? s : ((s > max_r) ? s : max_r);
      assign nxt_min = first_s ? s : ((s < min_r) ? s : min_r);

      always_ff @(posedge ad_clk or negedge rst_n) begin
         if (!rst_n) begin
            max_r <= '0;
            min_r <= '0;
         end else if (bus.restart) begin
            max_r <= '0;
            min_r <= '0;
         end else if (accept) begin
            max_r <= nxt_max;
            min_r <= nxt_min;
         end
      end

`ifdef DECIM_AVG_EN
      localparam int AW = DW + 15;
      logic [AW-1:0] acc, nxt_acc, shifted;

      // seeded with the first sample so a stale block never leaks in
      assign nxt_acc = first_s ? AW'(s) : acc + AW'(s);
      assign shifted = nxt_acc >> log2_e;
      assign res     = peak_e ? nxt_max : (avg_e ? shifted[DW-1:0] : s);

      always_ff @(posedge ad_clk or negedge rst_n) begin
         if (!rst_n)
            acc <= '0;
         else if (bus.restart)
            acc <= '0;
         else if (accept)
            acc <= nxt_acc;
      end
`else
      assign res = peak_e ? nxt_max : s;
`endif

      assign nxt_dout[c*DW +: DW] = res;
      assign nxt_dmin[c*DW +: DW] = peak_e ? nxt_min : res;
   end

   always_ff @(posedge ad_clk or negedge rst_n) begin
      if (!rst_n) begin
         first          <= 1'b1;
         cnt            <= '0;
         rate_l         <= '0;
         mode_l         <= '0;
         bus.dout_valid <= 1'b0;
         bus.dout       <= '0;
         bus.dout_min   <= '0;
      end else begin
         first          <= 1'b0;
         bus.dout_valid <= close;
         if (bus.restart || close || first) begin
            rate_l <= bus.deci_rate;
            mode_l <= bus.mode;
         end
         if (bus.restart) begin
            cnt <= '0;
         end else if (close) begin
            cnt          <= '0;
            bus.dout     <= nxt_dout;
            bus.dout_min <= nxt_dmin;
         end else if (accept) begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule
